ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
PS/2 keyboard receiver and key tracker. It samples the raw PS/2 clock and data lines, deframes 11-bit frames, and tracks make/break codes to hold the current key and a press count. It produces 5-bit nibble addresses that feed the hex-to-seven-segment ROM stage directly downstream. Address 16 selects that ROM's blank pattern.

Parameters:
TIMEOUT_CYCLES, 50000, clk cycles without a ps2_clk falling edge before a partial frame is aborted (1 ms at 50 MHz)
CNT_W, 8, width of the key press counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ps2_clk  in  1  PS/2 clock, asynchronous to clk
ps2_data  in  1  PS/2 data, asynchronous to clk
code_valid  out  1  one-cycle pulse when a frame is accepted
code  out  8  last accepted raw byte
frame_err  out  1  one-cycle pulse on a parity, stop-bit or timeout error
key_down  out  1  a key is currently held
key_code  out  8  make code of the held key; 0 when none is held
cnt  out  CNT_W  number of counted press events, wraps
code_hi_addr  out  5  {0,key_code[7:4]} when key_down, else 16
code_lo_addr  out  5  {0,key_code[3:0]} when key_down, else 16
cnt_hi_addr  out  5  {0,cnt[7:4]}
cnt_lo_addr  out  5  {0,cnt[3:0]}

Behaviour:
- Reset:
  - rst has priority over everything.
  - Reset values: code_valid=0, code=0, frame_err=0, key_down=0, key_code=0, cnt=0, code_hi_addr=code_lo_addr=16, cnt_hi_addr=cnt_lo_addr=0.
  - FSM goes to IDLE; bit counter, shift register, timeout counter and break_pending are all cleared.
  - rst asserted mid-frame discards the partial frame without raising frame_err.
- Input synchronisation: ps2_clk and ps2_data each pass through 2 flops. A third flop on ps2_clk gives edge detection. fall = prev & ~curr. Data is sampled only on a fall cycle.
- FSM states IDLE and RECV:
  - IDLE, on fall with data=0 (start bit): go to RECV, bitcnt=1. A fall with data=1 is ignored.
  - RECV, on each fall: shift in data. Bits 1..8 are data LSB first, bit 9 is parity, bit 10 is stop.
  - RECV, after bit 10 is sampled: the frame is valid if (^data ^ parity)==1 (odd parity) and stop==1. Return to IDLE either way.
  - RECV, timeout counter: cleared on each fall, incremented otherwise. When it reaches TIMEOUT_CYCLES: pulse frame_err, return to IDLE, keep break_pending unchanged.
- Frame outcome:
  - Valid frame: in the cycle after the stop-bit fall cycle, code_valid=1, code=byte, and the key-state updates below are visible together.
  - Invalid frame: frame_err=1 for one cycle; code and key state are unchanged.
- Latency: code_valid rises at most 4 clk cycles after the stop-bit ps2_clk falling edge at the pin.
- Key tracking on each accepted byte b:
  - b=F0: break_pending=1, nothing else changes.
  - b=E0: ignored; the extended prefix is transparent.
  - Other b with break_pending=1: clear break_pending. If key_down and b==key_code, then key_down=0 and key_code=0; otherwise no change.
  - Other b with break_pending=0 and !key_down: key_down=1, key_code=b, cnt+1.
  - Other b with break_pending=0, key_down, b==key_code: typematic repeat, no change.
  - Other b with break_pending=0, key_down, b!=key_code: key_code=b, cnt+1. The latest key wins; a later break of the older key is ignored.
- cnt wraps from 2^CNT_W-1 to 0.
- Address outputs are combinational from the registered key_down, key_code and cnt; they change in the same cycle those registers change.
- Frames arriving back-to-back must each be decoded; no inter-frame gap is required beyond the stop bit.

Test Plan:
1. Frame 0x1C (parity bit 0, stop 1) -> one code_valid pulse, code=1C, key_down=1, key_code=1C, cnt=1, code_hi_addr=1, code_lo_addr=12, cnt_lo_addr=1.
2. 1C repeated 3 times, then F0 1C -> 4 code_valid pulses for the 1C frames (plus 1 for F0), cnt stays 1; after the break key_down=0, key_code=0, code_hi_addr=code_lo_addr=16.
3. Frame 0x1C with parity bit 1 -> frame_err pulse, no code_valid, all key state unchanged. Repeat with stop bit 0 -> same result.
4. Start bit plus 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES -> frame_err pulse, FSM in IDLE; a following valid 0x32 frame decodes as code=32, key_code=32.
5. 256 make/break pairs of 0x1C -> cnt=0, cnt_hi_addr=0, cnt_lo_addr=0. Also 1C then 32 without a break -> key_code=32, cnt=2; then F0 1C -> key_down remains 1.
6. F0 accepted, then rst pulsed for 1 cycle, then 1C -> treated as a make: key_down=1, cnt=1. Also rst during bit 5 of a frame -> no code_valid and no frame_err; the next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_key_decoder_if.sv
// Bundle of PS/2 pin inputs and decoded key/address outputs for ps2_key_decoder.
// master is the decoder side; slave is the pin driver / display consumer side.
interface ps2_key_decoder_if #(
    parameter int CNT_W = 8
);
    logic             ps2_clk;
    logic             ps2_data;
    logic             code_valid;
    logic [7:0]       code;
    logic             frame_err;
    logic             key_down;
    logic [7:0]       key_code;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       code_hi_addr;
    logic [4:0]       code_lo_addr;
    logic [4:0]       cnt_hi_addr;
    logic [4:0]       cnt_lo_addr;

    modport master (
        input  ps2_clk, ps2_data,
        output code_valid, code, frame_err, key_down, key_code, cnt,
               code_hi_addr, code_lo_addr, cnt_hi_addr, cnt_lo_addr
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  code_valid, code, frame_err, key_down, key_code, cnt,
               code_hi_addr, code_lo_addr, cnt_hi_addr, cnt_lo_addr
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises the pins, deframes 11-bit frames and
// tracks make/break codes into a held key, a press count and blank-aware ROM addresses.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 8
) (
    input  logic               clk,
    input  logic               rst,
    ps2_key_decoder_if.master  bus
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, RECV = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [2:0]       clk_sync_q, clk_sync_d;
    logic [1:0]       data_sync_q, data_sync_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [8:0]       shift_q, shift_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             brk_q, brk_d;
    logic             key_down_q, key_down_d;
    logic [7:0]       key_code_q, key_code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       code_q, code_d;
    logic             code_valid_q, code_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             fall_s;
    logic             data_bit_s;
    logic             accept_s;
    logic [7:0]       byte_s;

    assign fall_s     = clk_sync_q[2] & ~clk_sync_q[1];
    assign data_bit_s = data_sync_q[1];
    assign byte_s     = shift_q[7:0];

    // Frame deframing FSM: start detect, bit shifting, stop/parity check and timeout
    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], bus.ps2_clk};
        data_sync_d = {data_sync_q[0], bus.ps2_data};
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        to_d        = to_q;
        accept_s    = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                to_d = '0;
                if (fall_s && !data_bit_s) begin
                    state_d  = RECV;
                    bitcnt_d = 4'd1;
                end else begin
                    state_d  = IDLE;
                end
            end
            RECV: begin
                if (fall_s) begin
                    to_d = '0;
                    if (bitcnt_q == 4'd10) begin
                        // shift_q holds data plus parity: odd parity means XOR of all nine is 1
                        state_d  = IDLE;
                        bitcnt_d = 4'd0;
                        if (((^shift_q) == 1'b1) && data_bit_s) begin
                            accept_s = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        shift_d  = {data_bit_s, shift_q[8:1]};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end else if (to_q == TO_LAST) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                    bitcnt_d    = 4'd0;
                    to_d        = '0;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                bitcnt_d = 4'd0;
                to_d     = '0;
            end
        endcase
    end

    // Key tracking on each accepted byte; F0 arms a break, E0 is transparent
    always_comb begin
        code_valid_d = 1'b0;
        code_d       = code_q;
        brk_d        = brk_q;
        key_down_d   = key_down_q;
        key_code_d   = key_code_q;
        cnt_d        = cnt_q;
        if (accept_s) begin
            code_valid_d = 1'b1;
            code_d       = byte_s;
            if (byte_s == 8'hF0) begin
                brk_d = 1'b1;
            end else if (byte_s == 8'hE0) begin
                brk_d = brk_q;
            end else if (brk_q) begin
                brk_d = 1'b0;
                if (key_down_q && (byte_s == key_code_q)) begin
                    key_down_d = 1'b0;
                    key_code_d = 8'h00;
                end else begin
                    key_down_d = key_down_q;
                end
            end else if (!key_down_q || (byte_s != key_code_q)) begin
                key_down_d = 1'b1;
                key_code_d = byte_s;
                cnt_d      = cnt_q + CNT_W'(1);
            end else begin
                key_code_d = key_code_q;
            end
        end else begin
            code_valid_d = 1'b0;
        end
    end

    // State registers; synchroniser flops reset to the idle-high line level
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            clk_sync_q   <= 3'b111;
            data_sync_q  <= 2'b11;
            bitcnt_q     <= 4'd0;
            shift_q      <= 9'd0;
            to_q         <= '0;
            brk_q        <= 1'b0;
            key_down_q   <= 1'b0;
            key_code_q   <= 8'h00;
            cnt_q        <= '0;
            code_q       <= 8'h00;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            to_q         <= to_d;
            brk_q        <= brk_d;
            key_down_q   <= key_down_d;
            key_code_q   <= key_code_d;
            cnt_q        <= cnt_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.code_valid   = code_valid_q;
    assign bus.code         = code_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.key_down     = key_down_q;
    assign bus.key_code     = key_code_q;
    assign bus.cnt          = cnt_q;
    // Address 16 is the ROM's blank glyph, shown while no key is held
    assign bus.code_hi_addr = key_down_q ? {1'b0, key_code_q[7:4]} : 5'd16;
    assign bus.code_lo_addr = key_down_q ? {1'b0, key_code_q[3:0]} : 5'd16;
    assign bus.cnt_hi_addr  = {1'b0, cnt_q[7:4]};
    assign bus.cnt_lo_addr  = {1'b0, cnt_q[3:0]};
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: drives PS/2 frames on the pins and compares
// outputs against a key-tracking reference model kept in the bench.
module tb_ps2_key_decoder;
    localparam int TO = 300;
    localparam int HB = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_pass = 0;
    int   n_total = 0;
    int   n_valid = 0;
    int   n_err = 0;

    logic       m_brk, m_down;
    logic [7:0] m_key, m_code;
    int         m_cnt;

    ps2_key_decoder_if #(.CNT_W(8)) bus ();
    ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.code_valid === 1'b1) n_valid++;
        if (bus.frame_err === 1'b1) n_err++;
    end

    task automatic model_reset();
        m_brk = 1'b0; m_down = 1'b0; m_key = 8'h00; m_code = 8'h00; m_cnt = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_code = b;
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b != 8'hE0) begin
            if (m_brk) begin
                m_brk = 1'b0;
                if (m_down && b == m_key) begin m_down = 1'b0; m_key = 8'h00; end
            end else if (!(m_down && b == m_key)) begin
                m_down = 1'b1; m_key = b; m_cnt = (m_cnt + 1) % 256;
            end
        end
    endtask

    function automatic logic [44:0] obs_vec();
        return {bus.code, bus.key_down, bus.key_code, bus.cnt,
                bus.code_hi_addr, bus.code_lo_addr, bus.cnt_hi_addr, bus.cnt_lo_addr};
    endfunction

    function automatic logic [44:0] exp_vec();
        logic [4:0] hi, lo, chi, clo;
        hi  = m_down ? 5'(int'(m_key) / 16) : 5'd16;
        lo  = m_down ? 5'(int'(m_key) % 16) : 5'd16;
        chi = 5'(m_cnt / 16);
        clo = 5'(m_cnt % 16);
        return {m_code, m_down, m_key, 8'(m_cnt), hi, lo, chi, clo};
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                              input int nbits, output int lat);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        lat = -1;
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = bits[i];
            repeat (HB) @(negedge clk);
            bus.ps2_clk = 1'b0;
            for (int k = 1; k <= HB; k++) begin
                @(negedge clk);
                if (i == 10 && lat < 0 && (bus.code_valid === 1'b1 || bus.frame_err === 1'b1)) lat = k;
            end
            bus.ps2_clk = 1'b1;
            if (i == 10) begin
                for (int k = HB + 1; k <= HB + 3; k++) begin
                    @(negedge clk);
                    if (lat < 0 && (bus.code_valid === 1'b1 || bus.frame_err === 1'b1)) lat = k;
                end
            end
        end
        bus.ps2_data = 1'b1;
    endtask

    task automatic pulse_reset(input int cycles);
        @(negedge clk); rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        bus.ps2_clk = 1'b1; bus.ps2_data = 1'b1;
        pulse_reset(3);
        #1;
        n_total++;
        if (obs_vec() !== {8'h00, 1'b0, 8'h00, 8'h00, 5'd16, 5'd16, 5'd0, 5'd0})
            $display("FAIL reset_state: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
        n_total++;
        if ({bus.code_valid, bus.frame_err} !== 2'b00)
            $display("FAIL reset_pulses: got %b expected 00", {bus.code_valid, bus.frame_err});
        else n_pass++;
    endtask

    task automatic test_basic();
        int lat, v0, e0;
        v0 = n_valid; e0 = n_err;
        send_frame(8'h1C, 1'b0, 1'b0, 11, lat); model_byte(8'h1C);
        #1;
        n_total++;
        if (lat < 1 || lat > 4) $display("FAIL basic_latency: got %0d cycles expected 1..4", lat);
        else n_pass++;
        n_total++;
        if (n_valid - v0 !== 1 || n_err - e0 !== 0)
            $display("FAIL basic_pulses: got valid=%0d err=%0d expected 1/0", n_valid - v0, n_err - e0);
        else n_pass++;
        n_total++;
        if (obs_vec() !== exp_vec()) $display("FAIL basic_state: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
        n_total++;
        if ({bus.code_hi_addr, bus.code_lo_addr, bus.cnt_lo_addr} !== {5'd1, 5'd12, 5'd1})
            $display("FAIL basic_addr: got %h expected %h", {bus.code_hi_addr, bus.code_lo_addr, bus.cnt_lo_addr},
                     {5'd1, 5'd12, 5'd1});
        else n_pass++;
    endtask

    task automatic test_typematic();
        int lat, v0;
        logic [7:0] seq [5] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
        v0 = n_valid;
        foreach (seq[i]) begin send_frame(seq[i], 1'b0, 1'b0, 11, lat); model_byte(seq[i]); end
        #1;
        n_total++;
        if (n_valid - v0 !== 5) $display("FAIL typematic_pulses: got %0d expected 5", n_valid - v0);
        else n_pass++;
        n_total++;
        if (obs_vec() !== exp_vec()) $display("FAIL typematic_state: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
        n_total++;
        if ({bus.key_down, bus.cnt, bus.code_hi_addr} !== {1'b0, 8'd1, 5'd16})
            $display("FAIL typematic_break: got %h expected %h", {bus.key_down, bus.cnt, bus.code_hi_addr},
                     {1'b0, 8'd1, 5'd16});
        else n_pass++;
    endtask

    task automatic test_errors();
        int lat, v0, e0;
        send_frame(8'h1C, 1'b0, 1'b0, 11, lat); model_byte(8'h1C);
        v0 = n_valid; e0 = n_err;
        send_frame(8'h1C, 1'b1, 1'b0, 11, lat);
        send_frame(8'h1C, 1'b0, 1'b1, 11, lat);
        #1;
        n_total++;
        if (n_valid - v0 !== 0 || n_err - e0 !== 2)
            $display("FAIL error_pulses: got valid=%0d err=%0d expected 0/2", n_valid - v0, n_err - e0);
        else n_pass++;
        n_total++;
        if (obs_vec() !== exp_vec()) $display("FAIL error_state: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_timeout();
        int lat, v0, e0;
        v0 = n_valid; e0 = n_err;
        send_frame(8'hA5, 1'b0, 1'b0, 5, lat);
        repeat (TO + 20) @(negedge clk);
        #1;
        n_total++;
        if (n_valid - v0 !== 0 || n_err - e0 !== 1)
            $display("FAIL timeout_pulses: got valid=%0d err=%0d expected 0/1", n_valid - v0, n_err - e0);
        else n_pass++;
        send_frame(8'h32, 1'b0, 1'b0, 11, lat); model_byte(8'h32);
        #1;
        n_total++;
        if (obs_vec() !== exp_vec() || bus.key_code !== 8'h32)
            $display("FAIL timeout_recover: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_wrap();
        int lat;
        logic [7:0] tail [4] = '{8'h1C, 8'h32, 8'hF0, 8'h1C};
        pulse_reset(1);
        for (int i = 0; i < 256; i++) begin
            send_frame(8'h1C, 1'b0, 1'b0, 11, lat); model_byte(8'h1C);
            send_frame(8'hF0, 1'b0, 1'b0, 11, lat); model_byte(8'hF0);
            send_frame(8'h1C, 1'b0, 1'b0, 11, lat); model_byte(8'h1C);
        end
        #1;
        n_total++;
        if (obs_vec() !== exp_vec() || bus.cnt !== 8'd0)
            $display("FAIL wrap_state: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
        for (int i = 0; i < 2; i++) begin send_frame(tail[i], 1'b0, 1'b0, 11, lat); model_byte(tail[i]); end
        #1;
        n_total++;
        if ({bus.key_code, bus.cnt} !== {8'h32, 8'd2})
            $display("FAIL rollover_key: got %h expected %h", {bus.key_code, bus.cnt}, {8'h32, 8'd2});
        else n_pass++;
        for (int i = 2; i < 4; i++) begin send_frame(tail[i], 1'b0, 1'b0, 11, lat); model_byte(tail[i]); end
        #1;
        n_total++;
        if (obs_vec() !== exp_vec() || bus.key_down !== 1'b1)
            $display("FAIL rollover_stale_break: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int lat, v0, e0;
        pulse_reset(1);
        send_frame(8'hF0, 1'b0, 1'b0, 11, lat);
        pulse_reset(1);
        send_frame(8'h1C, 1'b0, 1'b0, 11, lat); model_byte(8'h1C);
        #1;
        n_total++;
        if (obs_vec() !== exp_vec() || {bus.key_down, bus.cnt} !== {1'b1, 8'd1})
            $display("FAIL reset_clears_break: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
        v0 = n_valid; e0 = n_err;
        send_frame(8'h5A, 1'b0, 1'b0, 6, lat);
        pulse_reset(1);
        repeat (TO + 20) @(negedge clk);
        #1;
        n_total++;
        if (n_valid - v0 !== 0 || n_err - e0 !== 0)
            $display("FAIL midframe_reset_pulses: got valid=%0d err=%0d expected 0/0", n_valid - v0, n_err - e0);
        else n_pass++;
        send_frame(8'h32, 1'b0, 1'b0, 11, lat); model_byte(8'h32);
        #1;
        n_total++;
        if (obs_vec() !== exp_vec()) $display("FAIL midframe_recover: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_back_to_back_random();
        int lat, v0, e0, ev, ee, r;
        logic [7:0] b;
        logic bp, bs;
        logic [7:0] pool [4] = '{8'h1C, 8'h32, 8'h23, 8'h2B};
        for (int n = 0; n < 60; n++) begin
            v0 = n_valid; e0 = n_err;
            r = $urandom_range(0, 9);
            bp = 1'b0; bs = 1'b0;
            if (r < 2) b = 8'hF0;
            else if (r == 2) b = 8'hE0;
            else if (r == 3) begin b = 8'($urandom); bp = 1'($urandom); bs = ~bp | 1'($urandom); end
            else if (r == 4) b = 8'($urandom);
            else b = pool[$urandom_range(0, 3)];
            send_frame(b, bp, bs, 11, lat);
            if (bp || bs) begin ev = 0; ee = 1; end
            else begin model_byte(b); ev = 1; ee = 0; end
            #1;
            n_total++;
            if (n_valid - v0 !== ev || n_err - e0 !== ee || obs_vec() !== exp_vec())
                $display("FAIL random_frame_%0d: byte %h got v=%0d e=%0d %h expected v=%0d e=%0d %h",
                         n, b, n_valid - v0, n_err - e0, obs_vec(), ev, ee, exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        model_reset();
        test_reset();
        test_basic();
        test_typematic();
        test_errors();
        test_timeout();
        test_reset_midframe();
        test_back_to_back_random();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
